// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key-event receiver.
package ps2_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam logic [7:0] OVR_CODE0  = 8'h00;
  localparam logic [7:0] OVR_CODE1  = 8'hFF;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} frame_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchroniser, clock glitch filter and 11-bit frame deserialiser with timeout.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity or a low stop bit.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       err_o
);

  localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             flt_q, flt_d;
  logic [FiltW-1:0] flt_cnt_q, flt_cnt_d;
  logic             fall;
  logic             dat;

  frame_state_e     state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
`ifdef PS2_PARITY_CHECK_EN
  logic             par_q, par_d;
`endif

  assign dat = dat_sync_q[1];

  // The filtered level only flips after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    flt_d     = flt_q;
    flt_cnt_d = '0;
    if (clk_sync_q[1] != flt_q) begin
      if (flt_cnt_q == FiltW'(FILTER_LEN - 1)) flt_d = clk_sync_q[1];
      else flt_cnt_d = flt_cnt_q + FiltW'(1);
    end
  end

  assign fall = flt_q & ~flt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      flt_q      <= 1'b1;
      flt_cnt_q  <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      flt_q      <= flt_d;
      flt_cnt_q  <= flt_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_cnt_d = '0;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
`endif
    if (state_q != StIdle && !fall) begin
      if (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1)) begin
        state_d = StIdle;
        err_d   = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
      end
    end
    if (fall) begin
      case (state_q)
        StIdle: begin
          if (!dat) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shift_d   = {dat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = dat;
`endif
          state_d = StStop;
        end
        default: begin
          state_d = StIdle;
`ifdef PS2_PARITY_CHECK_EN
          if (dat && (^shift_q ^ par_q)) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
`else
          byte_d  = shift_q;
          valid_d = 1'b1;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_cnt_q <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_cnt_q <= tmo_cnt_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q     <= par_d;
`endif
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;
  assign err_o        = err_q;

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: folds E0/F0 prefixes into key events, queues them, stretches INTRPT.
// Parity/stop checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned INTRPT_CYC  = 6
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     PS2CLK,
  input  logic                     PS2DATA,
  input  logic                     RD_EN,
  input  logic                     CLR_OVF,
  output logic [9:0]               EVENT,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  output logic                     ERR,
  output logic                     INTRPT
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CntW = AW + 1;
  localparam int unsigned IrqW = $clog2(INTRPT_CYC + 1);

  logic [7:0]      frm_byte;
  logic            frm_valid, frm_err;
  logic            ext_q, ext_d, brk_q, brk_d;
  logic            push_q, push_d;
  key_event_t      push_ev_q, push_ev_d;
  logic [9:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [IrqW-1:0] irq_cnt_q, irq_cnt_d;
  logic            full, empty, do_push, do_pop;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_rx (
    .clk_i        (CLK),
    .rst_i        (reset),
    .ps2_clk_i    (PS2CLK),
    .ps2_data_i   (PS2DATA),
    .byte_o       (frm_byte),
    .byte_valid_o (frm_valid),
    .err_o        (frm_err)
  );

  // Prefix flags only survive from one accepted byte to the next; a rejected frame drops them.
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    push_d    = 1'b0;
    push_ev_d = push_ev_q;
    if (frm_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (frm_valid) begin
      if (frm_byte == EXT_CODE) begin
        ext_d = 1'b1;
      end else if (frm_byte == BREAK_CODE) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (frm_byte != OVR_CODE0 && frm_byte != OVR_CODE1) begin
          push_d         = 1'b1;
          push_ev_d.ext  = ext_q;
          push_ev_d.brk  = brk_q;
          push_ev_d.code = frm_byte;
        end
      end
    end
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = RD_EN && !empty;
  assign do_push = push_q && (!full || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // A same-cycle new drop wins over the clear.
    ovf_d = (ovf_q && !CLR_OVF) || (push_q && !do_push);
    if (do_push) irq_cnt_d = IrqW'(INTRPT_CYC);
    else if (irq_cnt_q != '0) irq_cnt_d = irq_cnt_q - IrqW'(1);
    else irq_cnt_d = irq_cnt_q;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      push_q    <= 1'b0;
      push_ev_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      irq_cnt_q <= '0;
    end else begin
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      push_q    <= push_d;
      push_ev_q <= push_ev_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      irq_cnt_q <= irq_cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_ev_q;
  end

  assign EVENT    = empty ? '0 : mem_q[rd_ptr_q];
  assign EMPTY    = empty;
  assign FULL     = full;
  assign COUNT    = count_q;
  assign OVERFLOW = ovf_q;
  assign ERR      = frm_err;
  assign INTRPT   = (irq_cnt_q != '0);

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Scoreboard bench for ps2_key_event_rx: PS/2 frames in, key events compared on pop.
module tb_ps2_key_event_rx;

  localparam int unsigned FLT    = 8;
  localparam int unsigned TMO    = 1000;
  localparam int unsigned DEP    = 16;
  localparam int unsigned IRQ    = 6;
  localparam int unsigned HALF   = 20;
  localparam int unsigned PP_OFS = 11;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2clk = 1'b1;
  logic       ps2dat = 1'b1;
  logic       tb_rd = 1'b0;
  logic       mon_rd = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       rd_en;
  logic [9:0] ev;
  logic       empty, full, ovf, err, irq;
  logic [4:0] count;

  assign rd_en = tb_rd | mon_rd;

  always #5 clk = ~clk;

  ps2_key_event_rx #(
    .FILTER_LEN  (FLT),
    .TIMEOUT_CYC (TMO),
    .DEPTH       (DEP),
    .INTRPT_CYC  (IRQ)
  ) dut (
    .CLK      (clk),
    .reset    (reset),
    .PS2CLK   (ps2clk),
    .PS2DATA  (ps2dat),
    .RD_EN    (rd_en),
    .CLR_OVF  (clr_ovf),
    .EVENT    (ev),
    .EMPTY    (empty),
    .FULL     (full),
    .COUNT    (count),
    .OVERFLOW (ovf),
    .ERR      (err),
    .INTRPT   (irq)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [9:0] exp_q[$];
  bit m_ext = 0, m_brk = 0, m_ovf = 0, auto_rd = 0;
  int exp_err = 0, err_edges = 0, err_hi = 0, irq_len = 0, irq_last = 0;
  logic err_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: one received byte under the prefix/overrun rules.
  task automatic model_byte(input logic [7:0] b, input bit rejected);
    if (rejected) begin
      m_ext = 0; m_brk = 0; exp_err++;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (b != 8'h00 && b != 8'hFF) begin
        if (exp_q.size() < DEP) exp_q.push_back({m_ext, m_brk, b});
        else m_ovf = 1;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  initial begin : err_irq_mon
    forever begin
      @(negedge clk);
      if (err) begin
        err_hi++;
        if (!err_prev) err_edges++;
      end
      err_prev = err;
      if (irq) irq_len++;
      else if (irq_len != 0) begin
        irq_last = irq_len;
        irq_len  = 0;
      end
    end
  end

  initial begin : scoreboard_mon
    forever begin
      @(negedge clk);
      if (mon_rd) begin
        mon_rd = 1'b0;
      end else if (auto_rd && !empty) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_event: got 0x%0h, expected none", ev);
        end else begin
          check("event", {22'd0, ev}, {22'd0, exp_q.pop_front()});
        end
        mon_rd = 1'b1;
      end
    end
  end

  task automatic ps2_bit(input logic b, input bit pp);
    @(negedge clk);
    ps2dat = b;
    repeat (HALF / 2) @(negedge clk);
    ps2clk = 1'b0;
    if (pp) begin
      // Pop exactly in the cycle the stop-bit push reaches the FIFO.
      repeat (PP_OFS) @(negedge clk);
      check("pp_head", {22'd0, ev}, {22'd0, exp_q.pop_front()});
      tb_rd = 1'b1;
      @(negedge clk);
      tb_rd = 1'b0;
      repeat (HALF - PP_OFS - 1) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2clk = 1'b1;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits, input bit pp);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], pp && (i == 10));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    send_frame(b, bad, 11, 1'b0);
    model_byte(b, bad && PARITY_EN);
  endtask

  task automatic send_key(input bit e, input bit k, input logic [7:0] code, input bit bad);
    if (e) send_byte(8'hE0, 1'b0);
    if (k) send_byte(8'hF0, 1'b0);
    send_byte(code, bad);
  endtask

  task automatic drain();
    int t = 0;
    auto_rd = 1;
    while ((exp_q.size() != 0 || !empty) && t < 200) begin
      @(negedge clk);
      t++;
    end
    auto_rd = 0;
    @(negedge clk);
    @(negedge clk);
    if (t >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d left, expected 0", exp_q.size());
      exp_q.delete();
    end
    check("count_after_drain", {27'd0, count}, 32'd0);
  endtask

  initial begin : watchdog
    #(10 * 95000);
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e0, t;
    repeat (3) @(negedge clk);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_event", {22'd0, ev}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single key, interrupt width.
    irq_last = 0;
    send_key(0, 0, 8'h1C, 0);
    check("t1_empty", {31'd0, empty}, 32'd0);
    check("t1_count", {27'd0, count}, 32'd1);
    check("t1_irq_len", irq_last, IRQ);
    drain();
    check("t1_empty_after", {31'd0, empty}, 32'd1);

    // Extended break key folds into one event.
    send_key(1, 1, 8'h75, 0);
    check("t2_count", {27'd0, count}, 32'd1);
    drain();

    // Overrun code clears pending prefix.
    send_byte(8'hE0, 0);
    send_byte(8'h00, 0);
    send_key(0, 0, 8'h1C, 0);
    check("t2b_count", {27'd0, count}, 32'd1);
    drain();

    // Randomised keys.
    for (int i = 0; i < 12; i++) begin
      send_key($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
      if (i % 4 == 3) drain();
    end
    send_byte(8'h00, 0);
    drain();

    // Fill past DEPTH, clear overflow, push+pop while full.
    for (int i = 0; i < DEP + 1; i++) send_key(0, 0, 8'(8'h11 + i), 0);
    check("t3_full", {31'd0, full}, 32'd1);
    check("t3_count", {27'd0, count}, DEP);
    check("t3_ovf", {31'd0, ovf}, {31'd0, m_ovf});
    check("t3_head", {22'd0, ev}, {22'd0, exp_q[0]});
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    m_ovf = 0;
    check("t3_ovf_clr", {31'd0, ovf}, 32'd0);
    send_frame(8'h33, 0, 11, 1'b1);
    model_byte(8'h33, 1'b0);
    check("t3_pp_count", {27'd0, count}, DEP);
    check("t3_pp_ovf", {31'd0, ovf}, {31'd0, m_ovf});
    drain();

    // Bad parity.
    send_key(0, 0, 8'h1C, 1);
    check("t4_err_count", err_edges, exp_err);
    check("t4_count", {27'd0, count}, {27'd0, 5'(exp_q.size())});
    drain();

    // Timeout after four bits.
    e0 = err_edges;
    send_frame(8'h2A, 0, 4, 1'b0);
    repeat (TMO - 100) @(negedge clk);
    check("t5_no_early_err", err_edges, e0);
    t = 0;
    while (err_edges == e0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    exp_err++;
    m_ext = 0; m_brk = 0;
    check("t5_timeout_err", err_edges, e0 + 1);
    send_key(0, 0, 8'h2A, 0);
    drain();

    // Reset mid-frame with FIFO non-empty and a prefix pending.
    send_key(0, 0, 8'h2B, 0);
    send_key(0, 0, 8'h2C, 0);
    send_byte(8'hE0, 0);
    send_frame(8'h1C, 0, 4, 1'b0);
    e0 = err_edges;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_empty", {31'd0, empty}, 32'd1);
    check("t6_count", {27'd0, count}, 32'd0);
    check("t6_irq", {31'd0, irq}, 32'd0);
    check("t6_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0;
    repeat (TMO + 100) @(negedge clk);
    check("t6_no_err", err_edges, e0);
    send_key(0, 0, 8'h1C, 0);
    drain();

    check("err_total", err_edges, exp_err);
    check("err_pulse_width", err_hi, err_edges);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
